lift_request_unit: RTL and testbench
====================================

# lift_request_unit

Front-end request stage for the four-floor lift controller. Synchronises and debounces the ten raw push-button inputs (six hall calls, four car-stop keys) and holds each press as a latched request bit until the lift serves that floor. Latched requests are presented as one-hot-per-floor vectors that the lift state machine consumes directly. The lift controller's door-open flag and one-hot position are fed back in to clear served requests.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clk cycles a synchronised input must differ from its debounced level before the level changes; legal range 2..255.

Ports:
- clk  input  1  divided system clock, rising-edge active
- reset  input  1  asynchronous, active-high
- btn_raw  input  10  raw buttons, active-high; [0]=up1, [1]=up2, [2]=up3, [3]=dn2, [4]=dn3, [5]=dn4, [6]=stop1, [7]=stop2, [8]=stop3, [9]=stop4
- pos  input  4  current floor, one-hot, bit0=floor1 … bit3=floor4
- door_open  input  1  high while the door is open at pos
- up_req  output  4  latched up calls {1'b0, up3, up2, up1}
- dn_req  output  4  latched down calls {dn4, dn3, dn2, 1'b0}
- stop_req  output  4  latched car stops {stop4, stop3, stop2, stop1}
- any_req  output  1  OR of all request bits
- press_pulse  output  10  one-cycle registered pulse per accepted press, same bit order as btn_raw

## Operation
- Per button: 2-flop synchroniser -> debouncer -> rising-edge detector -> request latch.
- Debouncer: counter cleared whenever synced level equals debounced level; increments while they differ; on the cycle where counter = DEBOUNCE_CYCLES-1 and still differing, debounced level toggles and counter clears.
- Edge detector: press_pulse[i] = debounced rises this cycle (registered); falling edges generate nothing.
- Latch set: press_pulse[i] high -> corresponding request bit set.
- Latch clear: at an edge with door_open=1, every up/dn/stop bit belonging to the floor selected by pos clears (direction-agnostic).
- Set and clear on the same edge for the same floor: clear wins (bit stays/goes 0); press is considered served.
- pos not one-hot (zero or multiple bits): no clears occur; sets unaffected.
- Bits up_req[3] and dn_req[0] are constant 0.
- any_req is combinational from the request registers only.

## Timing
- Reset: all synchroniser flops, debounced levels, counters, press_pulse, up_req, dn_req, stop_req = 0; any_req = 0. Reset mid-debounce discards the pending press.
- Press latency: raw high first sampled at edge k -> press_pulse high after edge k+2+DEBOUNCE_CYCLES for one cycle -> request bit high from edge k+3+DEBOUNCE_CYCLES (7 edges for default 4).
- Raw high for fewer than DEBOUNCE_CYCLES synchronised cycles: ignored, no pulse.
- Glitch low during a held press shorter than DEBOUNCE_CYCLES: no second pulse.
- Clear latency: door_open=1 and pos match sampled at edge m -> bit 0 after edge m.
- Held button through service: no re-latch until released (debounced low) and pressed again.

## Configuration
- REQ_CANCEL_EN defined: a pulse on a stop key whose stop_req bit is already 1 clears that bit (toggle/cancel); hall calls unaffected; clear-by-service still has priority.
- REQ_CANCEL_EN undefined: repeated presses of a latched request are idempotent (bit stays 1).

## Test plan
- Reset then idle: all outputs 0 for 20 cycles; assert reset mid-debounce of btn_raw[6] -> no stop_req[0] afterwards.
- btn_raw[1] high 10 cycles from edge 5, DEBOUNCE_CYCLES=4 -> press_pulse[1] high only after edge 11, up_req=4'b0010 from edge 12, any_req=1.
- btn_raw[5] high for 3 cycles -> no press_pulse, dn_req stays 4'b0000.
- up_req[1], dn_req[1], stop_req[1] latched; pos=4'b0010, door_open=1 one cycle -> all three bits 0 next edge; stop_req[3] set earlier remains 1.
- btn_raw[8] accepted on same edge as door_open=1, pos=4'b0100 -> stop_req[2] stays 0; with pos=4'b0000 instead -> stop_req[2]=1.
- REQ_CANCEL_EN: press stop2 twice (released between) -> stop_req[1] 1 then 0; without macro -> stays 1.

Source files
------------

// File: rtl/lift_request_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : lift_request_unit_if
// Purpose  : Bundles the lift request stage's button, feedback and request
//            signals into one interface.
// Signals  : btn_raw[9:0]     raw push buttons (master -> slave)
//            pos[3:0]         one-hot current floor (master -> slave)
//            door_open        door-open flag at pos (master -> slave)
//            up_req[3:0]      latched up calls (slave -> master)
//            dn_req[3:0]      latched down calls (slave -> master)
//            stop_req[3:0]    latched car stops (slave -> master)
//            any_req          OR of all requests (slave -> master)
//            press_pulse[9:0] one-cycle accepted-press pulses (slave -> master)
// Modports : master = lift controller / stimulus side, slave = request unit
// Revision : 1.0 - initial release
// ============================================================================
interface lift_request_unit_if;
  logic [9:0] btn_raw;
  logic [3:0] pos;
  logic       door_open;
  logic [3:0] up_req;
  logic [3:0] dn_req;
  logic [3:0] stop_req;
  logic       any_req;
  logic [9:0] press_pulse;

  modport master (
    output btn_raw, pos, door_open,
    input  up_req, dn_req, stop_req, any_req, press_pulse
  );

  modport slave (
    input  btn_raw, pos, door_open,
    output up_req, dn_req, stop_req, any_req, press_pulse
  );
endinterface
`default_nettype wire

// File: rtl/lift_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : lift_request_unit
// Purpose  : Front-end request stage of the four-floor lift controller.
//            Each of the ten raw buttons is synchronised (2 flops),
//            debounced, rising-edge detected and latched as a request bit
//            until the lift serves the floor (door open at a one-hot pos).
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous, active-high
//            bus    - lift_request_unit_if.slave: btn_raw, pos, door_open in;
//                     up_req, dn_req, stop_req, any_req, press_pulse out
// Params   : DEBOUNCE_CYCLES (2..255) - consecutive cycles a synchronised
//            level must differ before the debounced level follows it
// Options  : REQ_CANCEL_EN - when defined, pressing a stop key whose request
//            is already latched cancels that request
// Revision : 1.0 - initial release
// ============================================================================
module lift_request_unit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire                        clk,
  input  wire                        reset,
  lift_request_unit_if.slave         bus
);

  localparam int           c_nbtn     = 10;
  localparam logic [7:0]   c_cnt_last = 8'(DEBOUNCE_CYCLES - 1);

  logic [c_nbtn-1:0] w_pulse;

  // --------------------------------------------------------------------------
  // Per-button synchroniser, debouncer and rising-edge detector
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < c_nbtn; i++) begin : g_btn
    logic       r_s1;
    logic       r_s2;
    logic       r_lvl;
    logic       r_lvl_d;
    logic       r_pls;
    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_lvl   <= 1'b0;
        r_lvl_d <= 1'b0;
        r_pls   <= 1'b0;
        r_cnt   <= 8'd0;
      end else begin
        r_s1 <= bus.btn_raw[i];
        r_s2 <= r_s1;
        // Counter only runs while the synced level disagrees; any agreement
        // (e.g. a short glitch ending) restarts the qualification window.
        if (r_s2 == r_lvl) begin
          r_cnt <= 8'd0;
        end else if (r_cnt == c_cnt_last) begin
          r_lvl <= ~r_lvl;
          r_cnt <= 8'd0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
        r_lvl_d <= r_lvl;
        r_pls   <= r_lvl & ~r_lvl_d;
      end
    end

    assign w_pulse[i] = r_pls;
  end

  // --------------------------------------------------------------------------
  // Request latches
  // --------------------------------------------------------------------------
  logic [3:0] r_up;
  logic [3:0] r_dn;
  logic [3:0] r_stop;
  logic [3:0] w_set_up;
  logic [3:0] w_set_dn;
  logic [3:0] w_set_stop;
  logic [3:0] w_clr;
  logic [3:0] w_up_nxt;
  logic [3:0] w_dn_nxt;
  logic [3:0] w_stop_nxt;
  logic       w_pos_onehot;

  // Hall calls map onto floors: up1..up3 -> floors 1..3, dn2..dn4 -> 2..4.
  assign w_set_up   = {1'b0, w_pulse[2:0]};
  assign w_set_dn   = {w_pulse[5:3], 1'b0};
  assign w_set_stop = w_pulse[9:6];

  // A malformed position (none or several floors) must never clear anything.
  assign w_pos_onehot = (bus.pos != 4'b0000) &&
                        ((bus.pos & (bus.pos - 4'd1)) == 4'b0000);

  always_comb begin
    w_clr      = 4'b0000;
    w_up_nxt   = 4'b0000;
    w_dn_nxt   = 4'b0000;
    w_stop_nxt = 4'b0000;
    if (bus.door_open && w_pos_onehot) begin
      w_clr = bus.pos;
    end
    // Service clear is applied last so it beats a simultaneous set.
    w_up_nxt = (r_up | w_set_up) & ~w_clr;
    w_dn_nxt = (r_dn | w_set_dn) & ~w_clr;
`ifdef REQ_CANCEL_EN
    w_stop_nxt = (r_stop ^ w_set_stop) & ~w_clr;
`else
    w_stop_nxt = (r_stop | w_set_stop) & ~w_clr;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_up   <= 4'b0000;
      r_dn   <= 4'b0000;
      r_stop <= 4'b0000;
    end else begin
      r_up   <= w_up_nxt;
      r_dn   <= w_dn_nxt;
      r_stop <= w_stop_nxt;
    end
  end

  assign bus.up_req      = r_up;
  assign bus.dn_req      = r_dn;
  assign bus.stop_req    = r_stop;
  assign bus.any_req     = |{r_up, r_dn, r_stop};
  assign bus.press_pulse = w_pulse;

endmodule
`default_nettype wire

// File: tb/tb_lift_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_lift_request_unit
// Purpose  : Self-checking bench for lift_request_unit (DEBOUNCE_CYCLES=4).
//            Table of single-button presses plus hand-written sequences for
//            latency, reset, service clear, same-edge and cancel behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lift_request_unit;

  logic clk;
  logic reset;

  lift_request_unit_if bus ();

  lift_request_unit #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REQ_CANCEL_EN
  localparam logic c_cancel_exp = 1'b0;
`else
  localparam logic c_cancel_exp = 1'b1;
`endif

  int checks   = 0;
  int failures = 0;
  int pcnt     = 0;

  typedef struct {
    int         btn;
    int         hold;
    logic [3:0] up;
    logic [3:0] dn;
    logic [3:0] stop;
    int         pulses;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance n cycles; each step ends at a falling edge, where outputs are
  // sampled and inputs may be changed.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      pcnt += $countones(bus.press_pulse);
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.btn_raw   = '0;
    bus.pos       = '0;
    bus.door_open = 1'b0;
    cyc(3);
    reset = 1'b0;
    pcnt  = 0;
  endtask

  task automatic press(input int idx, input int hold);
    bus.btn_raw[idx] = 1'b1;
    cyc(hold);
    bus.btn_raw[idx] = 1'b0;
  endtask

  task automatic same_edge(input logic [3:0] p, input logic [3:0] exp_stop);
    logic found;
    do_reset();
    found = 1'b0;
    bus.btn_raw[8] = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (bus.press_pulse[8]) found = 1'b1;
    end
    chk("pulse8_seen", 32'(found), 32'd1);
    bus.pos       = p;
    bus.door_open = 1'b1;
    cyc(1);
    bus.door_open = 1'b0;
    bus.pos       = 4'b0000;
    bus.btn_raw   = '0;
    chk("same_edge_stop", 32'(bus.stop_req), 32'(exp_stop));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    //               btn hold up       dn       stop     pulses
    vecs[0]  = '{0, 10, 4'b0001, 4'b0000, 4'b0000, 1};
    vecs[1]  = '{1, 10, 4'b0010, 4'b0000, 4'b0000, 1};
    vecs[2]  = '{2, 10, 4'b0100, 4'b0000, 4'b0000, 1};
    vecs[3]  = '{3, 10, 4'b0000, 4'b0010, 4'b0000, 1};
    vecs[4]  = '{4, 10, 4'b0000, 4'b0100, 4'b0000, 1};
    vecs[5]  = '{5, 10, 4'b0000, 4'b1000, 4'b0000, 1};
    vecs[6]  = '{6, 10, 4'b0000, 4'b0000, 4'b0001, 1};
    vecs[7]  = '{7, 10, 4'b0000, 4'b0000, 4'b0010, 1};
    vecs[8]  = '{8, 10, 4'b0000, 4'b0000, 4'b0100, 1};
    vecs[9]  = '{9, 10, 4'b0000, 4'b0000, 4'b1000, 1};
    vecs[10] = '{5,  3, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[11] = '{7,  4, 4'b0000, 4'b0000, 4'b0010, 1};
    vecs[12] = '{0,  3, 4'b0000, 4'b0000, 4'b0000, 0};

    // Reset then idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("idle", 32'({bus.up_req, bus.dn_req, bus.stop_req, bus.any_req, bus.press_pulse}), 32'd0);
    end

    // Reset mid-debounce discards the pending stop1 press
    do_reset();
    bus.btn_raw[6] = 1'b1;
    cyc(3);
    reset = 1'b1;
    bus.btn_raw[6] = 1'b0;
    cyc(2);
    reset = 1'b0;
    pcnt  = 0;
    cyc(15);
    chk("midreset_stop", 32'(bus.stop_req), 32'd0);
    chk("midreset_pulses", 32'(pcnt), 32'd0);

    // Table of single presses
    for (int v = 0; v < 13; v++) begin
      do_reset();
      press(vecs[v].btn, vecs[v].hold);
      cyc(14);
      chk("vec_up", 32'(bus.up_req), 32'(vecs[v].up));
      chk("vec_dn", 32'(bus.dn_req), 32'(vecs[v].dn));
      chk("vec_stop", 32'(bus.stop_req), 32'(vecs[v].stop));
      chk("vec_any", 32'(bus.any_req), 32'(vecs[v].pulses != 0));
      chk("vec_pulses", 32'(pcnt), 32'(vecs[v].pulses));
    end

    // Exact latency: up2 first sampled at edge 5, pulse after edge 11,
    // request from edge 12.
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      cyc(1);
      chk("lat_pulse1", 32'(bus.press_pulse[1]), 32'(e == 11));
      chk("lat_up", 32'(bus.up_req), (e >= 12) ? 32'h2 : 32'h0);
      chk("lat_any", 32'(bus.any_req), 32'(e >= 12));
      if (e == 4)  bus.btn_raw[1] = 1'b1;
      if (e == 14) bus.btn_raw[1] = 1'b0;
    end

    // Service clear at floor 2, floor-4 stop untouched
    do_reset();
    bus.btn_raw = 10'b10_1000_1010;
    cyc(6);
    bus.btn_raw = '0;
    cyc(6);
    chk("svc_up_set", 32'(bus.up_req), 32'h2);
    chk("svc_dn_set", 32'(bus.dn_req), 32'h2);
    chk("svc_stop_set", 32'(bus.stop_req), 32'ha);
    bus.pos = 4'b0010;
    bus.door_open = 1'b1;
    cyc(1);
    bus.door_open = 1'b0;
    chk("svc_up_clr", 32'(bus.up_req), 32'h0);
    chk("svc_dn_clr", 32'(bus.dn_req), 32'h0);
    chk("svc_stop_keep", 32'(bus.stop_req), 32'h8);
    chk("svc_any_keep", 32'(bus.any_req), 32'd1);
    bus.pos = 4'b1000;
    bus.door_open = 1'b1;
    cyc(1);
    bus.door_open = 1'b0;
    bus.pos = 4'b0000;
    chk("svc_stop4_clr", 32'(bus.stop_req), 32'h0);
    chk("svc_any_clr", 32'(bus.any_req), 32'd0);

    // Same-edge set and clear: clear wins; invalid pos clears nothing
    same_edge(4'b0100, 4'b0000);
    same_edge(4'b0000, 4'b0100);
    bus.pos = 4'b0110;
    bus.door_open = 1'b1;
    cyc(1);
    bus.door_open = 1'b0;
    bus.pos = 4'b0000;
    chk("multihot_noclr", 32'(bus.stop_req), 32'h4);

    // Glitch low during a held press: one pulse only
    do_reset();
    bus.btn_raw[2] = 1'b1;
    cyc(8);
    bus.btn_raw[2] = 1'b0;
    cyc(2);
    bus.btn_raw[2] = 1'b1;
    cyc(8);
    bus.btn_raw[2] = 1'b0;
    cyc(12);
    chk("glitch_pulses", 32'(pcnt), 32'd1);
    chk("glitch_up", 32'(bus.up_req), 32'h4);

    // Held button through service: no re-latch until released and repressed
    do_reset();
    bus.btn_raw[0] = 1'b1;
    cyc(10);
    chk("held_set", 32'(bus.up_req), 32'h1);
    bus.pos = 4'b0001;
    bus.door_open = 1'b1;
    cyc(1);
    bus.door_open = 1'b0;
    chk("held_clr", 32'(bus.up_req), 32'h0);
    cyc(10);
    chk("held_no_relatch", 32'(bus.up_req), 32'h0);
    bus.btn_raw[0] = 1'b0;
    cyc(10);
    press(0, 6);
    cyc(8);
    chk("held_repress", 32'(bus.up_req), 32'h1);

    // Repeated stop press: cancel when enabled, idempotent otherwise
    do_reset();
    press(7, 6);
    cyc(10);
    chk("cancel_first", 32'(bus.stop_req), 32'h2);
    press(7, 6);
    cyc(10);
    chk("cancel_second", 32'(bus.stop_req), 32'({2'b00, c_cancel_exp, 1'b0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
